ps2_led_cmd_controller: RTL and testbench
=========================================

# ps2_led_cmd_controller

Host-to-keyboard command sequencer for the PS/2 keyboard path. It sends the "set LEDs" command (0xED, then an LED argument byte) through the PS/2 transmitter, and waits for the keyboard's 0xFA acknowledge through the existing receiver. It arbitrates the shared PS/2 lines by gating the receiver's `rx_en`, and it flags the ACK/RESEND bytes it consumes so the key identifier and FIFO ignore them.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2_000_000: max cycles to wait for `tx_done_tick` or for an ACK (20 ms at 100 MHz).
- `MAX_RETRY`, default 3: resend attempts per byte before the block reports an error.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: synchronous, active-high.
- `led_req`, in, 1: one-cycle request to update the LEDs.
- `led_state`, in, 3: {caps, num, scroll}, sampled when a request is accepted.
- `rx_done_tick`, in, 1: receiver byte strobe.
- `rx_data`, in, 8: received byte (`dout[8:1]`).
- `tx_idle`, in, 1: transmitter ready.
- `tx_done_tick`, in, 1: transmitter finished a byte.
- `rx_en`, out, 1: receiver enable.
- `tx_start`, out, 1: one-cycle transmit strobe.
- `tx_data`, out, 8: byte to transmit.
- `rx_claim`, out, 1: the current `rx_done_tick` byte is consumed by this block; the writer must suppress its FIFO write.
- `busy`, out, 1: a command sequence is in progress.
- `done_tick`, out, 1: sequence acknowledged.
- `error_tick`, out, 1: sequence abandoned.

## Operation
States:
- IDLE
- SEND_CMD: waits for `tx_idle`, then pulses `tx_start` with `tx_data`=0xED.
- WAIT_TX_CMD: waits for `tx_done_tick`.
- WAIT_ACK_CMD: waits for 0xFA.
- SEND_ARG: sends `tx_data`={5'b0, led_state_reg}.
- WAIT_TX_ARG
- WAIT_ACK_ARG
- DONE
- ERROR

Rules:
- **Request accept:** IDLE with `led_req`=1 latches `led_state` and goes to SEND_CMD.
- **Receiver gating:** `rx_en`=0 in SEND_* and WAIT_TX_*; `rx_en`=1 in every other state.
- **ACK handling in WAIT_ACK_*:**
  - `rx_done_tick` with 0xFA: go to the next stage (SEND_ARG, or DONE after the argument byte).
  - 0xFE or timeout: retry the same byte (back to SEND_CMD or SEND_ARG) and increment the retry count. If the count already equals `MAX_RETRY`, go to ERROR instead.
  - Any other byte: ignored by this block and passed on as a scan code.
- **`rx_claim`:** combinational. It is 1 only when `rx_done_tick`=1, the state is WAIT_ACK_*, and the byte is 0xFA or 0xFE.
- **TX timeout:** a timeout in WAIT_TX_* goes directly to ERROR (transmitter fault; no retry).
- **Retry counter:** width $clog2(MAX_RETRY+1). It clears at request accept and again at the move into SEND_ARG.
- **Timeout counter:** width $clog2(TIMEOUT_CYCLES+1). It clears on entry to each WAIT_* state and increments while in WAIT_*. Timeout fires when the count equals TIMEOUT_CYCLES-1.
- **Simultaneous `rx_done_tick`=0xFA and timeout:** the ACK wins.
- **DONE / ERROR:** each lasts one cycle and pulses `done_tick` or `error_tick` respectively, then returns to IDLE.
- **`led_req` while `busy`:** handled per the Configuration section.
- **Reset mid-sequence:** on the next edge the block is in IDLE with all outputs at reset values. A half-sent byte is not recovered.

## Timing
- **Reset values:** `rx_en`=1, `tx_start`=0, `tx_data`=0x00, `rx_claim`=0, `busy`=0, `done_tick`=0, `error_tick`=0; state IDLE; both counters 0.
- **Outputs:** all registered except `rx_claim`.
- **Request to `busy`:** a `led_req` accepted in cycle N gives `busy`=1 and `rx_en`=0 in N+1.
- **First transmit:** `tx_start` pulses in N+1 at the earliest (when `tx_idle`=1), with `tx_data` valid in the same cycle.
- **Phase advance:** the `tx_done_tick` cycle produces the WAIT_ACK state on the next cycle; the ACK cycle produces SEND_ARG or DONE on the next cycle.
- **Done/error pulses:** `done_tick` and `error_tick` are high for exactly one cycle; `busy` falls in the same cycle.

## Configuration
- Macro `PS2_LED_PENDING_EN`.
- **Defined:** a `led_req` while busy sets a one-deep pending flag and overwrites the latched pending `led_state` (the newest value wins). When the current sequence reaches DONE or ERROR, the pending request starts in SEND_CMD two cycles later, via IDLE.
- **Defined, request in the DONE cycle itself:** the request is captured as pending.
- **Not defined:** `led_req` while busy is dropped.

## Structure
- **Package `ps2_pkg`:** constants PS2_CMD_SET_LED=8'hED, PS2_ACK=8'hFA, PS2_RESEND=8'hFE, and the state enum `led_ctrl_state_t`.
- **Sub-module `ps2_timeout_timer`:** parameter TIMEOUT_CYCLES; inputs clear and enable; output `expired`.

## Test plan
- **Nominal sequence:** `led_req` with `led_state`=3'b101, keyboard answers 0xFA after each byte. Expect `tx_data` 0xED then 0x05, `rx_claim` on both ACKs, one `done_tick`, and `rx_en` low only during transmissions.
- **Resend recovery:** 0xFE after 0xED, then 0xFA after the resend. Expect 0xED sent twice, then 0x05, then `done_tick`; no `error_tick`.
- **Retries exhausted:** no ACK to the argument byte. Expect 1+MAX_RETRY=4 transmissions of 0x05 spaced by TIMEOUT_CYCLES (set to 100 in the bench), then `error_tick`, `busy`=0.
- **Scan code during ACK wait:** 0x1C arrives in WAIT_ACK_CMD. Expect `rx_claim`=0 and the state unchanged; a later 0xFA advances the sequence.
- **Pending request:** with `PS2_LED_PENDING_EN`, two `led_req` (3'b001 then 3'b111) while busy. Expect a second sequence sending 0x07. Without the macro, expect exactly one sequence.
- **Reset mid-sequence:** `reset` asserted in WAIT_TX_ARG. Expect all outputs at reset values on the next cycle, and a new `led_req` completes normally.

Source files
------------

// File: rtl/ps2_pkg.sv
// ----------------------------------------------------------------------------
// ps2_pkg
// Shared constants and state type for the PS/2 keyboard command path.
//   PS2_CMD_SET_LED : host "set LEDs" command byte
//   PS2_ACK         : keyboard acknowledge byte
//   PS2_RESEND      : keyboard resend request byte
//   led_ctrl_state_t: sequencer state of ps2_led_cmd_controller
// ----------------------------------------------------------------------------
package ps2_pkg;

    localparam logic [7:0] PS2_CMD_SET_LED = 8'hED;
    localparam logic [7:0] PS2_ACK         = 8'hFA;
    localparam logic [7:0] PS2_RESEND      = 8'hFE;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_SEND_CMD,
        ST_WAIT_TX_CMD,
        ST_WAIT_ACK_CMD,
        ST_SEND_ARG,
        ST_WAIT_TX_ARG,
        ST_WAIT_ACK_ARG,
        ST_DONE,
        ST_ERROR
    } led_ctrl_state_t;

    // States in which the timeout counter runs.
    function automatic logic is_wait(input led_ctrl_state_t s);
        return (s == ST_WAIT_TX_CMD) || (s == ST_WAIT_ACK_CMD) ||
               (s == ST_WAIT_TX_ARG) || (s == ST_WAIT_ACK_ARG);
    endfunction

    // States in which the host owns the PS/2 lines (receiver gated off).
    function automatic logic is_tx_phase(input led_ctrl_state_t s);
        return (s == ST_SEND_CMD) || (s == ST_WAIT_TX_CMD) ||
               (s == ST_SEND_ARG) || (s == ST_WAIT_TX_ARG);
    endfunction

    function automatic logic is_busy(input led_ctrl_state_t s);
        return (s != ST_IDLE) && (s != ST_DONE) && (s != ST_ERROR);
    endfunction

endpackage

// File: rtl/ps2_timeout_timer.sv
// ----------------------------------------------------------------------------
// ps2_timeout_timer
// Cycle counter for the sequencer's wait states.
//   clk, reset : system clock, synchronous active-high reset
//   clear      : restart the count from zero (wins over enable)
//   enable     : count this cycle
//   expired    : enable is high and the count has reached TIMEOUT_CYCLES-1,
//                i.e. this is the TIMEOUT_CYCLES-th enabled cycle since clear
// ----------------------------------------------------------------------------
module ps2_timeout_timer #(
    parameter int TIMEOUT_CYCLES = 2_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

    logic [CW-1:0] r_count;
    logic          w_at_last;

    assign w_at_last = (r_count == LAST);
    assign expired   = enable && w_at_last;

    // Holds at LAST so a caller that lingers cannot wrap the count.
    always_ff @(posedge clk) begin
        if (reset || clear) begin
            r_count <= '0;
        end else if (enable && !w_at_last) begin
            r_count <= r_count + CW'(1);
        end
    end

endmodule

// File: rtl/ps2_led_cmd_controller.sv
// ----------------------------------------------------------------------------
// ps2_led_cmd_controller
// Sends 0xED + LED argument to the keyboard through the PS/2 transmitter and
// waits for 0xFA after each byte, retrying on 0xFE or ACK timeout.
//   clk, reset   : system clock, synchronous active-high reset
//   led_req      : one-cycle LED update request, led_state {caps,num,scroll}
//   rx_done_tick : receiver byte strobe with rx_data
//   tx_idle      : transmitter ready; tx_done_tick: transmitter finished byte
//   rx_en        : receiver enable (low while the host drives the lines)
//   tx_start     : one-cycle transmit strobe, tx_data valid in same cycle
//   rx_claim     : current rx byte is an ACK/RESEND consumed here
//   busy, done_tick, error_tick : sequence status
// Optional feature macro: PS2_LED_PENDING_EN -- queue one request that arrives
// while a sequence is running (newest led_state wins); without it such
// requests are dropped.
// ----------------------------------------------------------------------------
module ps2_led_cmd_controller
    import ps2_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_000_000,
    parameter int MAX_RETRY      = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       led_req,
    input  logic [2:0] led_state,
    input  logic       rx_done_tick,
    input  logic [7:0] rx_data,
    input  logic       tx_idle,
    input  logic       tx_done_tick,
    output logic       rx_en,
    output logic       tx_start,
    output logic [7:0] tx_data,
    output logic       rx_claim,
    output logic       busy,
    output logic       done_tick,
    output logic       error_tick
);

    localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    led_ctrl_state_t r_state, w_next;

    logic [RW-1:0] r_retry;
    logic [2:0]    r_led_state;
    logic          r_rx_en, r_tx_start, r_busy, r_done, r_error;
    logic [7:0]    r_tx_data;

    logic          w_tx_start_nxt;
    logic [7:0]    w_tx_data_nxt;
    logic          w_retry_clr, w_retry_inc;
    logic          w_ack, w_resend, w_expired, w_in_ack;
    logic          w_pend_valid;
    logic [2:0]    w_pend_state;

    assign w_ack    = rx_done_tick && (rx_data == PS2_ACK);
    assign w_resend = rx_done_tick && (rx_data == PS2_RESEND);
    assign w_in_ack = (r_state == ST_WAIT_ACK_CMD) || (r_state == ST_WAIT_ACK_ARG);

    // Only ACK/RESEND seen while awaiting an ACK belong to this block; any other
    // byte is a scan code and must still reach the key identifier / FIFO.
    assign rx_claim = w_in_ack && (w_ack || w_resend);

    ps2_timeout_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (is_wait(w_next) && (w_next != r_state)),
        .enable (is_wait(r_state)),
        .expired(w_expired)
    );

`ifdef PS2_LED_PENDING_EN
    logic       r_pending;
    logic [2:0] r_pend_state;

    // Any request outside IDLE (including the DONE/ERROR cycle) is parked; IDLE
    // always consumes it because a pending flag forces the move to SEND_CMD.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pending    <= 1'b0;
            r_pend_state <= 3'b000;
        end else if (r_state == ST_IDLE) begin
            r_pending    <= 1'b0;
        end else if (led_req) begin
            r_pending    <= 1'b1;
            r_pend_state <= led_state;
        end
    end

    assign w_pend_valid = r_pending;
    assign w_pend_state = r_pend_state;
`else
    assign w_pend_valid = 1'b0;
    assign w_pend_state = 3'b000;
`endif

    // tx_start is registered, so the strobe for a SEND_* cycle is decided one
    // cycle earlier from tx_idle. A SEND_* state that has already strobed moves
    // on; one that has not keeps re-evaluating tx_idle.
    always_comb begin
        w_next         = r_state;
        w_tx_start_nxt = 1'b0;
        w_tx_data_nxt  = r_tx_data;
        w_retry_clr    = 1'b0;
        w_retry_inc    = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (led_req || w_pend_valid) begin
                    w_next         = ST_SEND_CMD;
                    w_tx_start_nxt = tx_idle;
                    w_tx_data_nxt  = PS2_CMD_SET_LED;
                    w_retry_clr    = 1'b1;
                end
            end
            ST_SEND_CMD: begin
                if (r_tx_start) w_next = ST_WAIT_TX_CMD;
                else            w_tx_start_nxt = tx_idle;
            end
            ST_WAIT_TX_CMD: begin
                if (tx_done_tick)   w_next = ST_WAIT_ACK_CMD;
                else if (w_expired) w_next = ST_ERROR;
            end
            ST_WAIT_ACK_CMD: begin
                if (w_ack) begin
                    w_next         = ST_SEND_ARG;
                    w_tx_start_nxt = tx_idle;
                    w_tx_data_nxt  = {5'b00000, r_led_state};
                    w_retry_clr    = 1'b1;
                end else if (w_resend || w_expired) begin
                    if (r_retry == RETRY_LIMIT) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next         = ST_SEND_CMD;
                        w_tx_start_nxt = tx_idle;
                        w_retry_inc    = 1'b1;
                    end
                end
            end
            ST_SEND_ARG: begin
                if (r_tx_start) w_next = ST_WAIT_TX_ARG;
                else            w_tx_start_nxt = tx_idle;
            end
            ST_WAIT_TX_ARG: begin
                if (tx_done_tick)   w_next = ST_WAIT_ACK_ARG;
                else if (w_expired) w_next = ST_ERROR;
            end
            ST_WAIT_ACK_ARG: begin
                if (w_ack) begin
                    w_next = ST_DONE;
                end else if (w_resend || w_expired) begin
                    if (r_retry == RETRY_LIMIT) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next         = ST_SEND_ARG;
                        w_tx_start_nxt = tx_idle;
                        w_retry_inc    = 1'b1;
                    end
                end
            end
            ST_DONE:  w_next = ST_IDLE;
            ST_ERROR: w_next = ST_IDLE;
            default:  w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_retry     <= '0;
            r_led_state <= 3'b000;
            r_rx_en     <= 1'b1;
            r_tx_start  <= 1'b0;
            r_tx_data   <= 8'h00;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_error     <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_tx_start <= w_tx_start_nxt;
            r_tx_data  <= w_tx_data_nxt;
            // Status outputs are decoded from the next state so they line up
            // with the state they describe.
            r_rx_en    <= !is_tx_phase(w_next);
            r_busy     <= is_busy(w_next);
            r_done     <= (w_next == ST_DONE);
            r_error    <= (w_next == ST_ERROR);

            if (w_retry_clr)      r_retry <= '0;
            else if (w_retry_inc) r_retry <= r_retry + RW'(1);

            // A fresh request beats a parked one: newest led_state wins.
            if (r_state == ST_IDLE) begin
                if (led_req)           r_led_state <= led_state;
                else if (w_pend_valid) r_led_state <= w_pend_state;
            end
        end
    end

    assign rx_en      = r_rx_en;
    assign tx_start   = r_tx_start;
    assign tx_data    = r_tx_data;
    assign busy       = r_busy;
    assign done_tick  = r_done;
    assign error_tick = r_error;

endmodule

// File: tb/tb_ps2_led_cmd_controller.sv
// ----------------------------------------------------------------------------
// Bench for ps2_led_cmd_controller. A phase-level model of the command
// sequence predicts every output each cycle; directed scenarios add literal
// checks on the transmitted byte log and on done/error/claim counts.
// ----------------------------------------------------------------------------
module tb_ps2_led_cmd_controller;

    localparam int T  = 100;
    localparam int MR = 3;

    logic       clk = 1'b0;
    logic       reset, led_req, rx_done_tick, tx_idle, tx_done_tick;
    logic [2:0] led_state;
    logic [7:0] rx_data;
    logic       rx_en, tx_start, rx_claim, busy, done_tick, error_tick;
    logic [7:0] tx_data;

    always #5 clk = ~clk;

    ps2_led_cmd_controller #(.TIMEOUT_CYCLES(T), .MAX_RETRY(MR)) dut (
        .clk(clk), .reset(reset), .led_req(led_req), .led_state(led_state),
        .rx_done_tick(rx_done_tick), .rx_data(rx_data), .tx_idle(tx_idle),
        .tx_done_tick(tx_done_tick), .rx_en(rx_en), .tx_start(tx_start),
        .tx_data(tx_data), .rx_claim(rx_claim), .busy(busy),
        .done_tick(done_tick), .error_tick(error_tick)
    );

    int n_cmp = 0, n_bad = 0;
    int done_cnt = 0, err_cnt = 0, claim_cnt = 0, cyc = 0;
    logic [7:0] tx_log[$];
    int         tx_cyc[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- phase-level model ----------------
    typedef enum {P_IDLE, P_SEND, P_TX, P_ACK, P_OK, P_ERR} ph_t;
    ph_t        ph = P_IDLE, p0;
    int         byte_i, tries, waited;
    logic [2:0] arg, parg;
    bit         pend = 0, m_start = 0, was_start, m_live = 0;
    logic [7:0] m_txd = 8'h00;

    task automatic m_go(input int b);
        ph      = P_SEND;
        byte_i  = b;
        m_start = tx_idle;
        m_txd   = (b != 0) ? {5'b0, arg} : 8'hED;
    endtask

    always @(posedge clk) begin
        m_live = 1;
        cyc++;
        if (reset) begin
            ph = P_IDLE; byte_i = 0; tries = 0; waited = 0;
            pend = 0; m_start = 0; m_txd = 8'h00;
        end else begin
            was_start = m_start;
            p0        = ph;
            m_start   = 0;
            case (p0)
                P_IDLE: begin
                    if (led_req) begin
                        arg = led_state; pend = 0; tries = 0; m_go(0);
                    end else if (pend) begin
                        arg = parg; pend = 0; tries = 0; m_go(0);
                    end
                end
                P_SEND: begin
                    if (was_start) begin ph = P_TX; waited = 0; end
                    else m_start = tx_idle;
                end
                P_TX: begin
                    if (tx_done_tick)      begin ph = P_ACK; waited = 0; end
                    else if (waited == T-1) ph = P_ERR;
                    else                    waited++;
                end
                P_ACK: begin
                    if (rx_done_tick && rx_data == 8'hFA) begin
                        if (byte_i == 0) begin tries = 0; m_go(1); end
                        else ph = P_OK;
                    end else if ((rx_done_tick && rx_data == 8'hFE) || waited == T-1) begin
                        if (tries == MR) ph = P_ERR;
                        else begin tries++; m_go(byte_i); end
                    end else begin
                        waited++;
                    end
                end
                default: ph = P_IDLE;
            endcase
`ifdef PS2_LED_PENDING_EN
            if (led_req && p0 != P_IDLE) begin pend = 1; parg = led_state; end
`endif
        end
    end

    // ---------------- per-cycle compare + event log ----------------
    always @(negedge clk) begin
        if (m_live) begin
            chk("busy",       busy,       (ph == P_SEND || ph == P_TX || ph == P_ACK));
            chk("rx_en",      rx_en,      !(ph == P_SEND || ph == P_TX));
            chk("tx_start",   tx_start,   m_start);
            chk("tx_data",    tx_data,    m_txd);
            chk("done_tick",  done_tick,  (ph == P_OK));
            chk("error_tick", error_tick, (ph == P_ERR));
            chk("rx_claim",   rx_claim,
                (ph == P_ACK) && rx_done_tick && (rx_data == 8'hFA || rx_data == 8'hFE));
            if (tx_start)   begin tx_log.push_back(tx_data); tx_cyc.push_back(cyc); end
            if (done_tick)  done_cnt++;
            if (error_tick) err_cnt++;
            if (rx_claim)   claim_cnt++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic clr_log();
        tx_log.delete(); tx_cyc.delete();
        done_cnt = 0; err_cnt = 0; claim_cnt = 0;
    endtask

    task automatic pulse_req(input logic [2:0] s);
        led_req = 1'b1; led_state = s; tick(); led_req = 1'b0;
    endtask

    task automatic wait_start(input string nm);
        int i = 0;
        while (!tx_start && i < 400) begin tick(); i++; end
        chk({nm, "_start_seen"}, tx_start, 1'b1);
    endtask

    // Wait for a strobe, let the byte "transmit" for one cycle, then finish it.
    task automatic send_ok(input string nm);
        wait_start(nm);
        tick();
        tx_done_tick = 1'b1; tick(); tx_done_tick = 1'b0;
    endtask

    task automatic reply(input logic [7:0] b);
        rx_done_tick = 1'b1; rx_data = b; tick();
        rx_done_tick = 1'b0; rx_data = 8'h00;
    endtask

    task automatic wait_idle(input string nm);
        int i = 0;
        while (busy && i < 400) begin tick(); i++; end
        chk({nm, "_idle"}, busy, 1'b0);
        tick(); tick();
    endtask

    task automatic chk_log(input string nm, input int n, input logic [7:0] b0,
                           input logic [7:0] bl);
        chk({nm, "_ntx"}, tx_log.size(), n);
        if (tx_log.size() == n && n > 0) begin
            chk({nm, "_first"}, tx_log[0], b0);
            chk({nm, "_last"},  tx_log[n-1], bl);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1; led_req = 0; led_state = 0; rx_done_tick = 0; rx_data = 0;
        tx_idle = 1; tx_done_tick = 0;
        repeat (3) tick();
        chk("rst_rx_en", rx_en, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_tx_data", tx_data, 8'h00);
        reset = 0; tick();

        // Nominal, with the argument ACK landing on the timeout cycle.
        clr_log();
        pulse_req(3'b101);
        chk("nom_busy_n1", busy, 1'b1);
        chk("nom_rxen_n1", rx_en, 1'b0);
        chk("nom_start_n1", tx_start, 1'b1);
        chk("nom_data_n1", tx_data, 8'hED);
        send_ok("nom_cmd");
        repeat (3) tick();
        reply(8'hFA);
        send_ok("nom_arg");
        repeat (T-1) tick();
        reply(8'hFA);
        wait_idle("nom");
        chk_log("nom", 2, 8'hED, 8'h05);
        chk("nom_done", done_cnt, 1);
        chk("nom_err", err_cnt, 0);
        chk("nom_claim", claim_cnt, 2);

        // Resend recovery, with the transmitter initially not idle.
        clr_log();
        tx_idle = 0;
        pulse_req(3'b101);
        repeat (3) tick();
        tx_idle = 1;
        send_ok("rs_cmd1"); reply(8'hFE);
        send_ok("rs_cmd2"); reply(8'hFA);
        send_ok("rs_arg");  reply(8'hFA);
        wait_idle("rs");
        chk_log("rs", 3, 8'hED, 8'h05);
        if (tx_log.size() == 3) chk("rs_second", tx_log[1], 8'hED);
        chk("rs_done", done_cnt, 1);
        chk("rs_err", err_cnt, 0);

        // Retries exhausted on the argument byte.
        clr_log();
        pulse_req(3'b101);
        send_ok("ex_cmd"); reply(8'hFA);
        repeat (1 + MR) send_ok("ex_arg");
        wait_idle("ex");
        chk_log("ex", 2 + MR, 8'hED, 8'h05);
        if (tx_cyc.size() == 2 + MR) chk("ex_spacing", tx_cyc[3] - tx_cyc[2], T + 2);
        chk("ex_err", err_cnt, 1);
        chk("ex_done", done_cnt, 0);

        // Scan code during ACK wait is passed through.
        clr_log();
        pulse_req(3'b010);
        send_ok("sc_cmd");
        tick();
        reply(8'h1C);
        chk("sc_claim_after_scan", claim_cnt, 0);
        chk("sc_busy_after_scan", busy, 1'b1);
        reply(8'hFA);
        send_ok("sc_arg"); reply(8'hFA);
        wait_idle("sc");
        chk_log("sc", 2, 8'hED, 8'h02);
        chk("sc_claim", claim_cnt, 2);
        chk("sc_done", done_cnt, 1);

        // Transmitter never finishes: straight to error, no retry.
        clr_log();
        pulse_req(3'b001);
        wait_start("tt");
        wait_idle("tt");
        chk_log("tt", 1, 8'hED, 8'hED);
        chk("tt_err", err_cnt, 1);

        // Requests while busy.
        clr_log();
        pulse_req(3'b101);
        send_ok("pd_cmd");
        pulse_req(3'b001);
        pulse_req(3'b111);
        reply(8'hFA);
        send_ok("pd_arg"); reply(8'hFA);
`ifdef PS2_LED_PENDING_EN
        send_ok("pd2_cmd"); reply(8'hFA);
        send_ok("pd2_arg"); reply(8'hFA);
        wait_idle("pd");
        chk_log("pd", 4, 8'hED, 8'h07);
        chk("pd_done", done_cnt, 2);
`else
        wait_idle("pd");
        repeat (20) tick();
        chk_log("pd", 2, 8'hED, 8'h05);
        chk("pd_done", done_cnt, 1);
`endif

        // Reset in WAIT_TX_ARG, then a clean sequence.
        clr_log();
        pulse_req(3'b011);
        send_ok("rm_cmd"); reply(8'hFA);
        wait_start("rm_arg");
        tick();
        reset = 1; tick();
        chk("rm_busy", busy, 1'b0);
        chk("rm_rx_en", rx_en, 1'b1);
        chk("rm_tx_start", tx_start, 1'b0);
        chk("rm_tx_data", tx_data, 8'h00);
        reset = 0; tick();
        clr_log();
        pulse_req(3'b110);
        send_ok("rm2_cmd"); reply(8'hFA);
        send_ok("rm2_arg"); reply(8'hFA);
        wait_idle("rm2");
        chk_log("rm2", 2, 8'hED, 8'h06);
        chk("rm2_done", done_cnt, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
